// File: rtl/rv_decode_pkg.sv
// Shared decode definitions: opcode constants, immediate-format selects,
// the decode-stage FSM states and the pipeline entry layout.
package rv_decode_pkg;

   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   typedef enum logic [2:0] {
      EXT_I     = 3'b000,
      EXT_U     = 3'b001,
      EXT_S     = 3'b010,
      EXT_B     = 3'b011,
      EXT_J     = 3'b100,
      EXT_SHAMT = 3'b101,
      EXT_NONE  = 3'b111
   } ext_op_e;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_e;

   typedef struct packed {
      ext_op_e ext_op;
      logic    illegal;
   } decode_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] pc;
      logic [63:0] imm;
      ext_op_e     ext_op;
      logic        illegal;
   } entry_t;

   // Classify an instruction word into its immediate format.
   function automatic decode_t decode_opcode(input logic [31:0] instr);
      decode_t d;
      d.ext_op  = EXT_NONE;
      d.illegal = 1'b0;
      case (instr[6:0])
         OPC_LUI, OPC_AUIPC:                          d.ext_op = EXT_U;
         OPC_JAL:                                     d.ext_op = EXT_J;
         OPC_JALR, OPC_LOAD, OPC_MISC_MEM, OPC_SYSTEM: d.ext_op = EXT_I;
         OPC_STORE:                                   d.ext_op = EXT_S;
         OPC_BRANCH:                                  d.ext_op = EXT_B;
         OPC_OP_IMM, OPC_OP_IMM_32:
            d.ext_op = (instr[13:12] == 2'b01) ? EXT_SHAMT : EXT_I;
         OPC_OP, OPC_OP_32:                           d.ext_op = EXT_NONE;
         default: begin
            d.ext_op  = EXT_NONE;
            d.illegal = 1'b1;
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/imm_64.sv
// Immediate extension: builds the sign-extended 64-bit immediate for the
// selected instruction format.
module imm_64
   import rv_decode_pkg::*;
(
   input  logic [31:0] instr,
   input  ext_op_e     ext_op,
   output logic [63:0] imm
);

   // Select and sign-extend the immediate field for the requested format.
   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      imm = '0;
      case (ext_op)
         EXT_I:     imm = {{52{instr[31]}}, instr[31:20]};
         EXT_U:     imm = {{32{instr[31]}}, instr[31:12], 12'b0};
         EXT_S:     imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
         EXT_B:     imm = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         EXT_J:     imm = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         // Shift-immediate: the arithmetic-shift flag in bit 10 is not part of shamt.
         EXT_SHAMT: imm = {{53{instr[31]}}, 1'b0, instr[29:20]};
         default:   imm = '0;
      endcase
   end

endmodule

// File: rtl/id_imm_ctrl.sv
// Decode-stage controller: classifies fetched instructions, extends their
// immediates and hands them to execute through an output register backed
// by a one-entry skid buffer. Intake halts after an illegal opcode until
// a flush.
module id_imm_ctrl
   import rv_decode_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_ext_op,
   output logic            out_illegal,
   output logic            halted
);

   state_e  state, state_n;
   logic    out_valid_q, out_valid_n;
   logic    skid_valid_q, skid_valid_n;
   logic    in_ready_q, in_ready_n;
   logic    load_out_new, load_out_skid, load_skid;
   entry_t  out_q, skid_q, in_entry;
   decode_t dec;
   logic [63:0] in_imm;
   logic    accept, out_free;

   assign dec = decode_opcode(in_instr);

   imm_64 u_imm (
      .instr  (in_instr),
      .ext_op (dec.ext_op),
      .imm    (in_imm)
   );

   // Entry as it would be captured on acceptance this cycle.
   always_comb begin
      in_entry.instr   = in_instr;
      in_entry.pc      = in_pc;
      in_entry.imm     = in_imm;
      in_entry.ext_op  = dec.ext_op;
      in_entry.illegal = dec.illegal;
   end

   assign accept   = in_valid & in_ready_q;
   assign out_free = ~out_valid_q | out_ready;

   // Next-state, buffer occupancy and load enables; flush overrides all.
   always_comb begin
      state_n       = state;
      out_valid_n   = out_valid_q;
      skid_valid_n  = skid_valid_q;
      load_out_new  = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      if (flush) begin
         out_valid_n  = 1'b0;
         skid_valid_n = 1'b0;
         state_n      = RUN;
      end else begin
         if (out_free) begin
            // Skid is older than anything arriving now, so it goes first.
            if (skid_valid_q) begin
               load_out_skid = 1'b1;
               skid_valid_n  = 1'b0;
               out_valid_n   = 1'b1;
            end else if (accept) begin
               load_out_new = 1'b1;
               out_valid_n  = 1'b1;
            end else begin
               out_valid_n = 1'b0;
            end
         end
         // in_ready is low whenever the skid is full, so this never overwrites.
         if (accept && !out_free) begin
            load_skid    = 1'b1;
            skid_valid_n = 1'b1;
         end
         if (accept && in_entry.illegal) state_n = HALT;
      end
      in_ready_n = ~skid_valid_n & (state_n == RUN) & ~flush;
   end

   // Control state: FSM, valid bits and the registered ready.
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RUN;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b0;
      end else begin
         state        <= state_n;
         out_valid_q  <= out_valid_n;
         skid_valid_q <= skid_valid_n;
         in_ready_q   <= in_ready_n;
      end
   end

   // Output register data; reset so execute sees defined fields after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q.instr   <= '0;
         out_q.pc      <= '0;
         out_q.imm     <= '0;
         out_q.ext_op  <= EXT_NONE;
         out_q.illegal <= 1'b0;
      end else if (load_out_skid) begin
         out_q <= skid_q;
      end else if (load_out_new) begin
         out_q <= in_entry;
      end
   end

   // Skid data register; only meaningful while skid_valid_q is set.
   // NOTE: data-only storage qualified by a valid bit needs no reset.
   always_ff @(posedge clk) begin
      if (load_skid) skid_q <= in_entry;
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_instr   = out_q.instr;
   assign out_pc      = out_q.pc;
   assign out_imm     = out_q.imm;
   assign out_ext_op  = out_q.ext_op;
   assign out_illegal = out_q.illegal;
   assign halted      = (state == HALT);

endmodule

// File: tb/tb_id_imm_ctrl.sv
// Self-checking bench for id_imm_ctrl: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_id_imm_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [63:0] in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic [63:0] out_imm;
   logic [2:0]  out_ext_op;
   logic        out_illegal;
   logic        halted;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
   } item_t;

   id_imm_ctrl #(.XLEN(64)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_imm     (out_imm),
      .out_ext_op  (out_ext_op),
      .out_illegal (out_illegal),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   // Reference format select straight from the opcode table.
   function automatic logic [2:0] ref_ext(input logic [31:0] i);
      case (i[6:0])
         7'h37, 7'h17:               return 3'b001;
         7'h6F:                      return 3'b100;
         7'h67, 7'h03, 7'h0F, 7'h73: return 3'b000;
         7'h23:                      return 3'b010;
         7'h63:                      return 3'b011;
         7'h13, 7'h1B:               return (i[14:12] == 3'b001 || i[14:12] == 3'b101) ? 3'b101 : 3'b000;
         default:                    return 3'b111;
      endcase
   endfunction

   function automatic logic ref_ill(input logic [31:0] i);
      case (i[6:0])
         7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h0F, 7'h73,
         7'h23, 7'h63, 7'h13, 7'h1B, 7'h33, 7'h3B: return 1'b0;
         default:                                  return 1'b1;
      endcase
   endfunction

   // Reference immediate: signed field values widened by assignment.
   function automatic logic [63:0] ref_imm(input logic [31:0] i);
      logic signed [11:0] s12;
      logic signed [31:0] s32;
      logic signed [12:0] s13;
      logic signed [20:0] s21;
      logic signed [63:0] v;
      v = 64'sd0;
      case (ref_ext(i))
         3'b000: begin s12 = i[31:20]; v = s12; end
         3'b001: begin s32 = {i[31:12], 12'h000}; v = s32; end
         3'b010: begin s12 = {i[31:25], i[11:7]}; v = s12; end
         3'b011: begin s13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; v = s13; end
         3'b100: begin s21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; v = s21; end
         3'b101: begin s12 = i[31:20]; v = s12; v = v & ~64'sh400; end
         default: v = 64'sd0;
      endcase
      return v;
   endfunction

   task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] p,
                        input logic ordy, input logic fl);
      in_valid  = v;
      in_instr  = ins;
      in_pc     = p;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic test_reset();
      drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (out_ext_op !== 3'b111) begin bad++; $display("FAIL reset_ext_op got=%b exp=111", out_ext_op); end
      total++; if (out_imm !== 64'h0) begin bad++; $display("FAIL reset_imm got=%h exp=0", out_imm); end
      total++; if ({out_instr, out_pc} !== 96'h0) begin bad++; $display("FAIL reset_instr_pc got=%h/%h exp=0", out_instr, out_pc); end
      total++; if ({out_illegal, halted} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", out_illegal, halted); end
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_addi();
      drive(1'b1, 32'hFFF00093, 64'h1000, 1'b1, 1'b0);
      @(negedge clk);
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b exp=1", out_valid); end
      total++; if (out_ext_op !== 3'b000) begin bad++; $display("FAIL addi_ext got=%b exp=000", out_ext_op); end
      total++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL addi_imm got=%h exp=ffffffffffffffff", out_imm); end
      total++; if (out_pc !== 64'h1000) begin bad++; $display("FAIL addi_pc got=%h exp=1000", out_pc); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL addi_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins [4];
      logic [2:0]  ext [4];
      logic [63:0] imm [4];
      ins[0] = 32'h4030D093; ext[0] = 3'b101; imm[0] = 64'h3;
      ins[1] = 32'h800000B7; ext[1] = 3'b001; imm[1] = 64'hFFFF_FFFF_8000_0000;
      ins[2] = 32'hFFDFF06F; ext[2] = 3'b100; imm[2] = 64'hFFFF_FFFF_FFFF_FFFC;
      ins[3] = 32'h00000463; ext[3] = 3'b011; imm[3] = 64'h8;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, ins[k], 64'(k * 4), 1'b1, 1'b0);
         @(negedge clk);
         total++; if (out_valid !== 1'b1 || out_instr !== ins[k]) begin bad++; $display("FAIL b2b_valid[%0d] got=%b/%h exp=1/%h", k, out_valid, out_instr, ins[k]); end
         total++; if (out_ext_op !== ext[k]) begin bad++; $display("FAIL b2b_ext[%0d] got=%b exp=%b", k, out_ext_op, ext[k]); end
         total++; if (out_imm !== imm[k]) begin bad++; $display("FAIL b2b_imm[%0d] got=%h exp=%h", k, out_imm, imm[k]); end
      end
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_backpressure();
      drive(1'b1, 32'h00100093, 64'h10, 1'b0, 1'b0);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
      drive(1'b1, 32'h00200093, 64'h14, 1'b0, 1'b0);
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready2 got=%b exp=0", in_ready); end
      drive(1'b1, 32'h00300093, 64'h18, 1'b0, 1'b0);
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready3 got=%b exp=0", in_ready); end
      total++; if (out_instr !== 32'h00100093 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold got=%h exp=00100093", out_instr); end
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      @(negedge clk);
      total++; if (out_instr !== 32'h00200093 || out_imm !== 64'h2) begin bad++; $display("FAIL bp_second got=%h/%h exp=00200093/2", out_instr, out_imm); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
   endtask

   task automatic test_illegal();
      drive(1'b1, 32'h00000000, 64'h40, 1'b1, 1'b0);
      @(negedge clk);
      total++; if ({out_valid, out_illegal, halted} !== 3'b111) begin bad++; $display("FAIL ill_flags got=%b%b%b exp=111", out_valid, out_illegal, halted); end
      total++; if (out_ext_op !== 3'b111 || in_ready !== 1'b0) begin bad++; $display("FAIL ill_ext_ready got=%b/%b exp=111/0", out_ext_op, in_ready); end
      drive(1'b1, 32'h00000013, 64'h44, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      total++; if ({out_valid, in_ready, halted} !== 3'b001) begin bad++; $display("FAIL ill_blocked got=%b%b%b exp=001", out_valid, in_ready, halted); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      total++; if ({halted, in_ready, out_valid} !== 3'b000) begin bad++; $display("FAIL ill_flush got=%b%b%b exp=000", halted, in_ready, out_valid); end
      @(negedge clk);
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL ill_ready_back got=%b/%b exp=1/0", in_ready, out_valid); end
      @(negedge clk);
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      total++; if (out_valid !== 1'b1 || out_instr !== 32'h13 || out_illegal !== 1'b0) begin bad++; $display("FAIL ill_resume got=%b/%h/%b exp=1/00000013/0", out_valid, out_instr, out_illegal); end
      @(negedge clk);
   endtask

   task automatic test_flush();
      drive(1'b1, 32'h00500093, 64'h80, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 32'h00600093, 64'h84, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 32'h00700093, 64'h88, 1'b0, 1'b1);
      @(negedge clk);
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL flush_clear got=%b/%b exp=0/0", out_valid, in_ready); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_after got=%b/%b exp=0/1", out_valid, in_ready); end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [6:0]  op;
      w = $urandom;
      case ($urandom_range(0, 15))
         0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;
         4: op = 7'h03;  5: op = 7'h0F;  6: op = 7'h73;  7: op = 7'h23;
         8: op = 7'h63;  9: op = 7'h13;  10: op = 7'h1B; 11: op = 7'h33;
         12: op = 7'h3B; 13: op = 7'h13;
         default: op = w[6:0];
      endcase
      w[6:0] = op;
      return w;
   endfunction

   task automatic test_random();
      item_t       q[$];
      logic        halt_m, blk, exp_rdy, v, ordy, fl, acc, drn;
      logic [31:0] ins;
      logic [63:0] p;
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b1);
      @(negedge clk);
      halt_m = 1'b0;
      blk    = 1'b1;
      for (int c = 0; c < 500; c++) begin
         exp_rdy = !blk && !halt_m && (q.size() <= 1);
         total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
         total++; if (out_valid !== (q.size() > 0)) begin bad++; $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, out_valid, q.size() > 0); end
         total++; if (halted !== halt_m) begin bad++; $display("FAIL rnd_halted c=%0d got=%b exp=%b", c, halted, halt_m); end
         if (q.size() > 0) begin
            total++;
            if (out_instr !== q[0].instr || out_pc !== q[0].pc || out_ext_op !== ref_ext(q[0].instr) ||
                out_imm !== ref_imm(q[0].instr) || out_illegal !== ref_ill(q[0].instr)) begin
               bad++;
               $display("FAIL rnd_entry c=%0d got=%h/%h/%b/%h/%b exp=%h/%h/%b/%h/%b", c,
                        out_instr, out_pc, out_ext_op, out_imm, out_illegal,
                        q[0].instr, q[0].pc, ref_ext(q[0].instr), ref_imm(q[0].instr), ref_ill(q[0].instr));
            end
         end
         v    = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 3) != 0);
         fl   = ($urandom_range(0, 39) == 0);
         ins  = rand_instr();
         p    = {$urandom, $urandom};
         drive(v, ins, p, ordy, fl);
         acc = v && exp_rdy;
         drn = (q.size() > 0) && ordy;
         if (fl) begin
            q.delete();
            halt_m = 1'b0;
            blk    = 1'b1;
         end else begin
            blk = 1'b0;
            if (drn) void'(q.pop_front());
            if (acc) begin
               q.push_back('{instr: ins, pc: p});
               if (ref_ill(ins)) halt_m = 1'b1;
            end
         end
         @(negedge clk);
      end
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b1);
      @(negedge clk);
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      drive(1'b1, 32'hABCDE0B7, 64'h200, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 32'h00000000, 64'h204, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL arst_valid_ready got=%b/%b exp=0/0", out_valid, in_ready); end
      total++; if (out_ext_op !== 3'b111 || out_imm !== 64'h0 || out_instr !== 32'h0 || out_pc !== 64'h0) begin bad++; $display("FAIL arst_data got=%b/%h/%h/%h exp=111/0/0/0", out_ext_op, out_imm, out_instr, out_pc); end
      total++; if (halted !== 1'b0 || out_illegal !== 1'b0) begin bad++; $display("FAIL arst_flags got=%b/%b exp=0/0", halted, out_illegal); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL arst_release got=%b/%b exp=1/0", in_ready, out_valid); end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_back_to_back();
      test_backpressure();
      test_illegal();
      test_flush();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
